// File: rtl/pwm_pkg.sv
// Shared types for the PWM tick generator: FSM states, default width, shadow config.
// PWM_POLARITY_INV_EN selects the inverted (idle-high) output polarity.
package pwm_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default-width config pair; the generator declares a CNT_W-sized twin of it.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] duty;
  } shadow_cfg_t;

`ifdef PWM_POLARITY_INV_EN
  localparam logic PWM_IDLE_LVL = 1'b1;
`else
  localparam logic PWM_IDLE_LVL = 1'b0;
`endif

endpackage

// File: rtl/tick_edge_det.sv
// One-flop rising-edge detector for a divided clock that is treated as data.
// A level held high for any number of clk cycles yields exactly one pulse.
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_rise
);

  logic tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_in;
  end

  assign tick_rise = tick_in & ~tick_q;

endmodule

// File: rtl/pwm_tick_gen.sv
// PWM generator stepped by rising edges of tick_in, with a shadowed period/duty
// config applied at period boundaries. Build option: PWM_POLARITY_INV_EN.
//
// cfg handshake: a transfer happens on a clk edge where cfg_valid & cfg_ready;
// the sender holds cfg_valid and its data stable until then, and cfg_ready
// stays low while a captured config waits in the shadow register.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  cfg_t             shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;

  logic             tick_rise;
  logic             cfg_hs;
  logic             wrap;
  logic             xfer;
  logic [CNT_W-1:0] last_cnt;

  tick_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .tick_rise (tick_rise)
  );

  assign cfg_hs   = cfg_valid & ~pending_q;
  assign last_cnt = (period_act_q != '0) ? (period_act_q - CNT_ONE) : '0;
  assign wrap     = (state_q == RUN) & tick_rise & (count_q == last_cnt);
  // Shadow drains immediately when idle, otherwise only at a period boundary.
  assign xfer     = pending_q & ((state_q == IDLE) | wrap);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pwm_d        = 1'b0;
    done_d       = wrap;

    if (xfer) begin
      period_act_d = shadow_q.period;
      duty_act_d   = shadow_q.duty;
      pending_d    = 1'b0;
    end
    if (cfg_hs) begin
      shadow_d.period = cfg_period;
      shadow_d.duty   = cfg_duty;
      pending_d       = 1'b1;
    end

    case (state_q)
      IDLE: begin
        count_d = '0;
        // Start on the effective period so RUN never holds a zero period.
        if (en && (period_act_d != '0)) state_d = RUN;
      end
      RUN: begin
        if (tick_rise) count_d = wrap ? '0 : (count_q + CNT_ONE);
        if (!en || (period_act_d == '0)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          pwm_d = (count_d < duty_act_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= PWM_IDLE_LVL;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d ^ PWM_IDLE_LVL;
      done_q       <= done_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Bench for pwm_tick_gen: directed scenarios plus random traffic, scored against
// a per-cycle reference model through an expected-output queue.
module tb_pwm_tick_gen;

`ifdef PWM_POLARITY_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       tick_in;
  logic       cfg_valid;
  logic [7:0] cfg_period;
  logic [7:0] cfg_duty;
  logic       cfg_ready;
  logic       pwm_out;
  logic       period_done;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {cfg_ready, pwm_out, period_done, busy} per clk
  logic [3:0] exp_q[$];

  // tick generator state used by the driver
  bit tick_auto;
  int tick_div;
  int tick_ph;

  // reference model state
  bit m_run, m_pend, m_prev;
  int m_step, m_per, m_duty, m_sp, m_sd;

  pwm_tick_gen #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tick_in     (tick_in),
    .cfg_valid   (cfg_valid),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_ready   (cfg_ready),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_prev = 0;
    m_step = 0; m_per = 0; m_duty = 0; m_sp = 0; m_sd = 0;
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    bit rise, hs, done, keep, lvl;
    done = 0;
    lvl  = 0;
    if (rst) begin
      model_reset();
    end else begin
      rise   = tick_in && !m_prev;
      m_prev = tick_in;
      hs     = cfg_valid && !m_pend;
      if (!m_run) begin
        if (m_pend) begin m_per = m_sp; m_duty = m_sd; m_pend = 0; end
        if (en && m_per != 0) begin m_run = 1; m_step = 0; end
      end else begin
        keep = 1;
        if (rise) begin
          if (m_step == m_per - 1) begin
            m_step = 0;
            done   = 1;
            if (m_pend) begin
              m_per = m_sp; m_duty = m_sd; m_pend = 0;
              if (m_per == 0) keep = 0;
            end
          end else begin
            m_step++;
          end
        end
        if (!en) keep = 0;
        if (keep) lvl = (m_step < m_duty);
        else begin m_run = 0; m_step = 0; end
      end
      if (hs) begin m_sp = int'(cfg_period); m_sd = int'(cfg_duty); m_pend = 1; end
    end
    exp_q.push_back({!m_pend, lvl ^ INV, done, m_run});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [3:0] act, exp_v;
    act = {cfg_ready, pwm_out, period_done, busy};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow t=%0t act=%b required=expectation", $time, act);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t {rdy,pwm,done,busy} act=%b required=%b", $time, act, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void check(string name, int act, int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s act=%0d required=%0d", name, act, exp_v);
    end
  endfunction

  task automatic step();
    bit acc;
    acc = cfg_valid && cfg_ready;
    @(posedge clk);
    #1;
    if (acc) cfg_valid = 1'b0;
    if (tick_auto) begin
      tick_ph = (tick_ph + 1) % tick_div;
      tick_in = (tick_ph == 0);
    end
  endtask

  task automatic load_cfg(input int p, input int d);
    cfg_period = 8'(p);
    cfg_duty   = 8'(d);
    cfg_valid  = 1'b1;
    for (int i = 0; i < 200 && cfg_valid; i++) step();
    check("cfg_accept_timeout", int'(cfg_valid), 0);
    cfg_valid = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst_outs", int'({cfg_ready, pwm_out, period_done, busy}),
             int'({1'b1, INV, 1'b0, 1'b0}));
    #1 rst = 1'b0;
  endtask

  task automatic measure(input int n, output int hi, output int dn, output int bz);
    hi = 0; dn = 0; bz = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(pwm_out);
      dn += int'(period_done);
      bz += int'(busy);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi, dn, bz, early;
    bit found;
    rst = 1'b1; en = 1'b0; tick_in = 1'b0;
    cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
    tick_auto = 1; tick_div = 4; tick_ph = 0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // bring-up: tick every 4 clk, period 4, duty 1
    load_cfg(4, 1);
    en = 1'b1;
    repeat (40) step();
    measure(64, hi, dn, bz);
    check("bringup_high", hi, INV ? 48 : 16);
    check("bringup_done", dn, 4);

    // duty extremes and zero period
    load_cfg(4, 0);
    repeat (40) step();
    measure(32, hi, dn, bz);
    check("duty0_high", hi, INV ? 32 : 0);
    load_cfg(4, 6);
    repeat (40) step();
    measure(32, hi, dn, bz);
    check("duty_ge_period_high", hi, INV ? 0 : 32);
    load_cfg(0, 2);
    repeat (40) step();
    measure(20, hi, dn, bz);
    check("period0_busy", bz, 0);

    // mid-period reconfig with a second offer held while pending
    load_cfg(4, 2);
    repeat (30) step();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = m_run && m_step == 1; end
    check("midcfg_reach_step1", int'(found), 1);
    load_cfg(4, 3);
    cfg_period = 8'd4; cfg_duty = 8'd1; cfg_valid = 1'b1;
    found = 0; early = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (period_done) found = 1;
      else early += int'(cfg_ready);
    end
    check("midcfg_done_seen", int'(found), 1);
    check("midcfg_ready_blocked", early, 0);
    check("midcfg_second_held", int'(cfg_valid), 1);
    hi = int'(pwm_out);
    for (int i = 0; i < 15; i++) begin step(); hi += int'(pwm_out); end
    check("midcfg_new_duty", hi, INV ? 4 : 12);
    for (int i = 0; i < 40 && cfg_valid; i++) step();
    cfg_valid = 1'b0;
    repeat (40) step();

    // enable drop at count 2, then restart
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = m_run && m_step == 2; end
    check("endrop_reach_step2", int'(found), 1);
    en = 1'b0;
    step();
    check("endrop_outs", int'({pwm_out, busy, period_done}), int'({INV, 1'b0, 1'b0}));
    repeat (3) step();
    en = 1'b1;
    repeat (40) step();

    // async reset during RUN; active config must be gone afterwards
    async_reset();
    measure(20, hi, dn, bz);
    check("postrst_busy", bz, 0);
    check("postrst_pwm_idle", hi, INV ? 20 : 0);

    // tick held high for 10 clk counts as a single step
    load_cfg(4, 1);
    repeat (40) step();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = period_done; end
    check("hold_done_seen", int'(found), 1);
    tick_auto = 0; tick_in = 1'b0;
    repeat (3) step();
    dn = 0;
    tick_in = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); dn += int'(period_done); end
    tick_in = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); dn += int'(period_done); end
    check("hold_no_wrap", dn, 0);
    check("hold_pwm_after_one_step", int'(pwm_out), int'(INV));

    // random traffic
    for (int i = 0; i < 900; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) en = ~en;
      if (!cfg_valid && $urandom_range(0, 19) == 0) begin
        cfg_period = 8'($urandom_range(0, 6));
        cfg_duty   = 8'($urandom_range(0, 8));
        cfg_valid  = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) async_reset();
      step();
    end

    en = 1'b0; cfg_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
